// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller: FSM state encoding
// and the per-direction {red,yellow,green} lamp codes.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_ALLRED,
    ST_GREEN,
    ST_YELLOW,
    ST_WALK,
    ST_FLASH
  } state_t;

  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_GREEN  = 3'b001;
  localparam logic [2:0] LT_DARK   = 3'b000;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that parks at zero; o_zero flags the final cycle
// of a phase so the controller can leave it on the next edge.
module phase_timer #(
  parameter int            TW      = 8,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  output logic          o_zero
);

  logic [TW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= RST_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Round-robin traffic light controller with pedestrian walk phase and a
// flashing-yellow fallback mode; NUM_DIR must be at least 2.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIR  = 2,
  parameter int TW       = 8,
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int PED_T    = 5,
  parameter int FLASH_T  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       ped_req,
  output logic [3*NUM_DIR-1:0]       light,
  output logic                       ped_walk,
  output logic [$clog2(NUM_DIR)-1:0] dir_idx
);

  localparam int            DW        = $clog2(NUM_DIR);
  localparam logic [TW-1:0] LD_GREEN  = TW'(GREEN_T - 1);
  localparam logic [TW-1:0] LD_YELLOW = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] LD_ALLRED = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] LD_PED    = TW'(PED_T - 1);
  localparam logic [TW-1:0] LD_FLASH  = TW'(FLASH_T - 1);
  localparam logic [DW-1:0] DIR_LAST  = DW'(NUM_DIR - 1);

  state_t              r_state;
  logic [DW-1:0]       r_dir;
  logic                r_pend;
  logic                r_flash_ph;
  logic [TW-1:0]       r_flash_cnt;
  logic [3*NUM_DIR-1:0] r_light;
  logic                r_ped_walk;

  state_t              w_state_nxt;
  logic [DW-1:0]       w_dir_nxt;
  logic                w_pend_nxt;
  logic                w_flash_ph_nxt;
  logic [TW-1:0]       w_flash_cnt_nxt;
  logic                w_load;
  logic [TW-1:0]       w_load_val;
  logic                w_zero;

  phase_timer #(
    .TW      (TW),
    .RST_VAL (LD_ALLRED)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  function automatic logic [3*NUM_DIR-1:0] decode(input state_t s,
                                                  input logic [DW-1:0] d,
                                                  input logic ph);
    logic [3*NUM_DIR-1:0] l;
    l = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      case (s)
        ST_GREEN:  l[3*i +: 3] = (d == DW'(i)) ? LT_GREEN : LT_RED;
        ST_YELLOW: l[3*i +: 3] = (d == DW'(i)) ? LT_YELLOW : LT_RED;
        ST_FLASH:  l[3*i +: 3] = ph ? LT_DARK : LT_YELLOW;
        default:   l[3*i +: 3] = LT_RED;
      endcase
    end
    return l;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_dir_nxt       = r_dir;
    w_flash_ph_nxt  = r_flash_ph;
    w_flash_cnt_nxt = r_flash_cnt;
    w_load          = 1'b0;
    w_load_val      = '0;
    w_pend_nxt      = r_pend | (ped_req && (r_state != ST_WALK));

    if (!enable) begin
      // Disable outranks any timer expiry; flashing starts on the yellow half.
      if (r_state != ST_FLASH) begin
        w_state_nxt     = ST_FLASH;
        w_flash_ph_nxt  = 1'b0;
        w_flash_cnt_nxt = LD_FLASH;
      end else if (r_flash_cnt == '0) begin
        w_flash_ph_nxt  = ~r_flash_ph;
        w_flash_cnt_nxt = LD_FLASH;
      end else begin
        w_flash_cnt_nxt = r_flash_cnt - 1'b1;
      end
    end else begin
      case (r_state)
        ST_FLASH: begin
          w_state_nxt    = ST_ALLRED;
          w_dir_nxt      = '0;
          w_flash_ph_nxt = 1'b0;
          w_load         = 1'b1;
          w_load_val     = LD_ALLRED;
        end
        ST_GREEN: if (w_zero) begin
          w_state_nxt = ST_YELLOW;
          w_load      = 1'b1;
          w_load_val  = LD_YELLOW;
        end
        ST_YELLOW: if (w_zero) begin
          w_state_nxt = ST_ALLRED;
          w_dir_nxt   = (r_dir == DIR_LAST) ? '0 : r_dir + 1'b1;
          w_load      = 1'b1;
          w_load_val  = LD_ALLRED;
        end
        ST_ALLRED: if (w_zero) begin
          w_load = 1'b1;
          if (r_pend || ped_req) begin
            w_state_nxt = ST_WALK;
            w_pend_nxt  = 1'b0;
            w_load_val  = LD_PED;
          end else begin
            w_state_nxt = ST_GREEN;
            w_load_val  = LD_GREEN;
          end
        end
        ST_WALK: if (w_zero) begin
          w_state_nxt = ST_GREEN;
          w_load      = 1'b1;
          w_load_val  = LD_GREEN;
        end
        default: begin
          w_state_nxt = ST_ALLRED;
          w_load      = 1'b1;
          w_load_val  = LD_ALLRED;
        end
      endcase
    end
  end

  // Lamps are registered from the next state, so pins change on the same
  // edge as the state and no input reaches them combinationally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_ALLRED;
      r_dir       <= '0;
      r_pend      <= 1'b0;
      r_flash_ph  <= 1'b0;
      r_flash_cnt <= '0;
      r_light     <= {NUM_DIR{LT_RED}};
      r_ped_walk  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dir       <= w_dir_nxt;
      r_pend      <= w_pend_nxt;
      r_flash_ph  <= w_flash_ph_nxt;
      r_flash_cnt <= w_flash_cnt_nxt;
      r_light     <= decode(w_state_nxt, w_dir_nxt, w_flash_ph_nxt);
      r_ped_walk  <= (w_state_nxt == ST_WALK);
    end
  end

  assign light    = r_light;
  assign ped_walk = r_ped_walk;
  assign dir_idx  = r_dir;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench: vector table through a scoreboard, hand-written
// reset/flash sequences, and a three-direction rotation check.
module tb_traffic_light_ctrl;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       ped_req;
  logic [5:0] light;
  logic       ped_walk;
  logic [0:0] dir_idx;
  logic [8:0] light3;
  logic       ped_walk3;
  logic [1:0] dir3;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       en;
    logic       pr;
    logic [5:0] light;
    logic       walk;
    logic       dir;
  } vec_t;

  typedef struct {
    string      name;
    logic [8:0] light;
    logic       walk;
    logic [1:0] dir;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  traffic_light_ctrl #(
    .NUM_DIR(2), .TW(8), .GREEN_T(4), .YELLOW_T(2),
    .ALLRED_T(1), .PED_T(3), .FLASH_T(2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .ped_req  (ped_req),
    .light    (light),
    .ped_walk (ped_walk),
    .dir_idx  (dir_idx)
  );

  traffic_light_ctrl #(
    .NUM_DIR(3), .TW(8), .GREEN_T(4), .YELLOW_T(2),
    .ALLRED_T(1), .PED_T(3), .FLASH_T(2)
  ) dut3 (
    .clock    (clock),
    .reset    (reset),
    .enable   (1'b1),
    .ped_req  (1'b0),
    .light    (light3),
    .ped_walk (ped_walk3),
    .dir_idx  (dir3)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic add(input int n, input logic en, input logic pr,
                     input logic [5:0] l, input logic w, input logic d);
    vec_t v;
    v.en = en; v.pr = pr; v.light = l; v.walk = w; v.dir = d;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Drive at the falling edge, expect the state after the next rising edge.
  task automatic step(input string nm, input logic en, input logic pr,
                      input logic [5:0] l, input logic w, input logic d);
    exp_t e;
    enable  = en;
    ped_req = pr;
    e.name  = nm;
    e.light = {3'b000, l};
    e.walk  = w;
    e.dir   = {1'b0, d};
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check({e.name, "_light"}, 16'(light), 16'(e.light));
    check({e.name, "_walk"}, 16'(ped_walk), 16'(e.walk));
    check({e.name, "_dir"}, 16'(dir_idx), 16'(e.dir));
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_light"}, 16'(light), 16'(6'b100_100));
    check({nm, "_walk"}, 16'(ped_walk), 16'(1'b0));
    check({nm, "_dir"}, 16'(dir_idx), 16'(1'b0));
  endtask

  initial begin
    logic [8:0] exp3;
    int         d;

    reset   = 1'b1;
    enable  = 1'b1;
    ped_req = 1'b0;
    #12;
    check_reset_outputs("in_reset");
    @(negedge clock);
    reset = 1'b0;
    check_reset_outputs("first_allred");

    // Normal rotation, then pulse request during dir0 green.
    add(4, 1, 0, 6'b100_001, 0, 0);
    add(2, 1, 0, 6'b100_010, 0, 0);
    add(1, 1, 0, 6'b100_100, 0, 1);
    add(4, 1, 0, 6'b001_100, 0, 1);
    add(2, 1, 0, 6'b010_100, 0, 1);
    add(1, 1, 0, 6'b100_100, 0, 0);
    add(1, 1, 0, 6'b100_001, 0, 0);
    add(1, 1, 1, 6'b100_001, 0, 0);
    add(2, 1, 0, 6'b100_001, 0, 0);
    add(2, 1, 0, 6'b100_010, 0, 0);
    add(1, 1, 0, 6'b100_100, 0, 1);
    add(3, 1, 0, 6'b100_100, 1, 1);
    add(4, 1, 0, 6'b001_100, 0, 1);
    add(2, 1, 0, 6'b010_100, 0, 1);
    add(1, 1, 0, 6'b100_100, 0, 0);
    // Request only in the last all-red cycle, held through walk.
    add(3, 1, 1, 6'b100_100, 1, 0);
    add(1, 1, 1, 6'b100_001, 0, 0);
    add(3, 1, 0, 6'b100_001, 0, 0);
    add(2, 1, 0, 6'b100_010, 0, 0);
    add(1, 1, 0, 6'b100_100, 0, 1);
    add(4, 1, 0, 6'b001_100, 0, 1);
    add(2, 1, 0, 6'b010_100, 0, 1);
    // Disable on the yellow expiry cycle; request while flashing.
    add(2, 0, 0, 6'b010_010, 0, 1);
    add(1, 0, 1, 6'b000_000, 0, 1);
    add(1, 0, 0, 6'b000_000, 0, 1);
    add(1, 0, 0, 6'b010_010, 0, 1);
    add(1, 1, 0, 6'b100_100, 0, 0);
    add(3, 1, 0, 6'b100_100, 1, 0);
    add(1, 1, 0, 6'b100_001, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i + 1), vecs[i].en, vecs[i].pr,
           vecs[i].light, vecs[i].walk, vecs[i].dir);
    end

    // Reset in the middle of a walk phase.
    step("h_req", 1, 1, 6'b100_001, 0, 0);
    step("h_g1", 1, 0, 6'b100_001, 0, 0);
    step("h_g0", 1, 0, 6'b100_001, 0, 0);
    step("h_y1", 1, 0, 6'b100_010, 0, 0);
    step("h_y0", 1, 0, 6'b100_010, 0, 0);
    step("h_ar", 1, 0, 6'b100_100, 0, 1);
    step("h_w2", 1, 0, 6'b100_100, 1, 1);
    step("h_w1", 1, 0, 6'b100_100, 1, 1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_mid_walk");
    @(negedge clock);
    reset = 1'b0;
    step("after_walk_rst", 1, 0, 6'b100_001, 0, 0);

    // Reset in the middle of flash with a request pending.
    step("f_enter", 0, 0, 6'b010_010, 0, 0);
    step("f_req", 0, 1, 6'b010_010, 0, 0);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_mid_flash");
    @(negedge clock);
    reset = 1'b0;
    step("after_flash_rst", 1, 0, 6'b100_001, 0, 0);

    // Three-direction rotation: green at edges 1,8,15,22; all-red at 7,14,21.
    #2 reset = 1'b1;
    @(negedge clock);
    reset   = 1'b0;
    enable  = 1'b1;
    ped_req = 1'b0;
    for (int n = 1; n <= 22; n++) begin
      @(posedge clock);
      #1;
      if (n % 7 == 1) begin
        d = (n / 7) % 3;
        for (int i = 0; i < 3; i++) exp3[3*i +: 3] = (i == d) ? 3'b001 : 3'b100;
        check($sformatf("nd3_light_e%0d", n), 16'(light3), 16'(exp3));
        check($sformatf("nd3_dir_e%0d", n), 16'(dir3), 16'(d));
        check($sformatf("nd3_walk_e%0d", n), 16'(ped_walk3), 16'(1'b0));
      end else if (n % 7 == 0) begin
        check($sformatf("nd3_adv_e%0d", n), 16'(dir3), 16'((n / 7) % 3));
      end
      @(negedge clock);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
